// File: rtl/mem_sync_server_pkg.sv
// mem_sync_pkg: shared widths, FSM state type and bank-index helper for the row-cache sync server
package mem_sync_pkg;
  localparam int BG_W = 2;
  localparam int BA_W = 2;
  localparam int CH_W = 5;
  localparam int ADDR_W = 17;
  localparam int BEAT_W = 3;
  localparam int ROWBEATS = 2**BEAT_W;
  typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_e;
  function automatic int unsigned bank_idx(int unsigned bg, int unsigned ba, int unsigned baw);
    return (bg << baw) | ba;
  endfunction
endpackage

// File: rtl/mem_sync_server_if.sv
// mem_sync_server_if: bank-side sync requests plus the backing-store beat channel
interface mem_sync_server_if
  import mem_sync_pkg::*;
#(
  parameter int BGWIDTH = BG_W,
  parameter int BAWIDTH = BA_W,
  parameter int CHWIDTH = CH_W,
  parameter int ADDRWIDTH = ADDR_W,
  parameter int BEATW = BEAT_W
);
  localparam int BG = 2**BGWIDTH;
  localparam int BA = 2**BAWIDTH;
  localparam int BSAW = BGWIDTH + BAWIDTH + ADDRWIDTH + BEATW;
  localparam int CSAW = BGWIDTH + BAWIDTH + CHWIDTH + BEATW;
  logic [BG-1:0][BA-1:0] req, req_wb, ack;
  logic [ADDRWIDTH-1:0] req_row [BG-1:0][BA-1:0];
  logic [ADDRWIDTH-1:0] req_old_row [BG-1:0][BA-1:0];
  logic [CHWIDTH-1:0] req_crow [BG-1:0][BA-1:0];
  logic busy;
  logic [BGWIDTH-1:0] gnt_bg;
  logic [BAWIDTH-1:0] gnt_ba;
  logic bs_cmd_valid, bs_cmd_ready, bs_cmd_we, bs_rvalid, cs_we;
  logic [BSAW-1:0] bs_cmd_addr;
  logic [CSAW-1:0] cs_addr;
  modport master (
    input req, req_wb, req_row, req_old_row, req_crow, bs_cmd_ready, bs_rvalid,
    output ack, busy, gnt_bg, gnt_ba, bs_cmd_valid, bs_cmd_we, bs_cmd_addr, cs_addr, cs_we
  );
  modport slave (
    output req, req_wb, req_row, req_old_row, req_crow, bs_cmd_ready, bs_rvalid,
    input ack, busy, gnt_bg, gnt_ba, bs_cmd_valid, bs_cmd_we, bs_cmd_addr, cs_addr, cs_we
  );
endinterface

// File: rtl/mem_sync_rr_arb.sv
// mem_sync_rr_arb: N-wide round-robin pick of the first unmasked request at or after ptr_i
module mem_sync_rr_arb #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  logic [W-1:0] j;
  // scan from the far end so the nearest index to ptr_i is the last write and wins
  always_comb begin
    valid_o = 1'b0;
    idx_o = ptr_i;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = ptr_i + W'(k);
      if (req_i[j] && !mask_i[j]) begin
        valid_o = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/mem_sync_server.sv
// mem_sync_server: serves bank row-cache sync requests one at a time (write-back, then fill)
module mem_sync_server
  import mem_sync_pkg::*;
#(
  parameter int BGWIDTH = BG_W,
  parameter int BAWIDTH = BA_W,
  parameter int CHWIDTH = CH_W,
  parameter int ADDRWIDTH = ADDR_W,
  parameter int BEATW = BEAT_W
) (
  input logic clk,
  input logic reset_n,
  mem_sync_server_if.master bus
);
  localparam int IW = BGWIDTH + BAWIDTH;
  localparam int NB = 2**IW;
  localparam logic [BEATW:0] RB = {1'b1, {BEATW{1'b0}}};
  state_e state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d, rr_q, rr_d, arb_idx;
  logic [NB-1:0] mask_q, mask_d, req_flat, wb_flat;
  logic [ADDRWIDTH-1:0] row_q, row_d, old_q, old_d;
  logic [CHWIDTH-1:0] crow_q, crow_d;
  logic [BEATW:0] wcnt_q, wcnt_d, ccnt_q, ccnt_d, rcnt_q, rcnt_d;
  logic arb_v, fire;
  assign req_flat = bus.req;
  assign wb_flat = bus.req_wb;
  mem_sync_rr_arb #(.N(NB)) u_arb (
    .req_i(req_flat), .mask_i(mask_q), .ptr_i(rr_q), .valid_o(arb_v), .idx_o(arb_idx)
  );
  assign fire = bus.bs_cmd_valid && bus.bs_cmd_ready;
  assign bus.busy = state_q == WB || state_q == RD;
  assign bus.gnt_bg = gnt_q[IW-1:BAWIDTH];
  assign bus.gnt_ba = gnt_q[BAWIDTH-1:0];
  assign bus.bs_cmd_valid = state_q == WB || (state_q == RD && ccnt_q != RB);
  assign bus.bs_cmd_we = state_q == WB;
  assign bus.bs_cmd_addr = state_q == WB ? {gnt_q, old_q, wcnt_q[BEATW-1:0]} : {gnt_q, row_q, ccnt_q[BEATW-1:0]};
  assign bus.cs_we = state_q == RD && bus.bs_rvalid && rcnt_q != RB;
  assign bus.cs_addr = {gnt_q, crow_q, state_q == WB ? wcnt_q[BEATW-1:0] : rcnt_q[BEATW-1:0]};
  assign bus.ack = state_q == DONE ? NB'(1) << gnt_q : '0;
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    rr_d = rr_q;
    mask_d = mask_q;
    row_d = row_q;
    old_d = old_q;
    crow_d = crow_q;
    wcnt_d = wcnt_q + {{BEATW{1'b0}}, state_q == WB && fire};
    ccnt_d = ccnt_q + {{BEATW{1'b0}}, state_q == RD && fire};
    rcnt_d = rcnt_q + {{BEATW{1'b0}}, bus.cs_we};
    case (state_q)
      IDLE: begin
        mask_d = '0;
        if (arb_v) begin
          gnt_d = arb_idx;
          row_d = bus.req_row[arb_idx[IW-1:BAWIDTH]][arb_idx[BAWIDTH-1:0]];
          old_d = bus.req_old_row[arb_idx[IW-1:BAWIDTH]][arb_idx[BAWIDTH-1:0]];
          crow_d = bus.req_crow[arb_idx[IW-1:BAWIDTH]][arb_idx[BAWIDTH-1:0]];
          state_d = wb_flat[arb_idx] ? WB : RD;
        end
      end
      WB: state_d = wcnt_d == RB ? RD : WB;
      RD: state_d = rcnt_d == RB ? DONE : RD;
      default: begin
        rr_d = gnt_q + 1'b1;
        mask_d = NB'(1) << gnt_q;
        wcnt_d = '0;
        ccnt_d = '0;
        rcnt_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rr_q <= '0;
      mask_q <= '0;
      row_q <= '0;
      old_q <= '0;
      crow_q <= '0;
      wcnt_q <= '0;
      ccnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rr_q <= rr_d;
      mask_q <= mask_d;
      row_q <= row_d;
      old_q <= old_d;
      crow_q <= crow_d;
      wcnt_q <= wcnt_d;
      ccnt_q <= ccnt_d;
      rcnt_q <= rcnt_d;
    end
  end
endmodule

// File: tb/tb_mem_sync_server.sv
// tb_mem_sync_server: scoreboard bench with a one-cycle-latency backing store and acking banks
module tb_mem_sync_server;
  import mem_sync_pkg::*;
  localparam int NB = 16;
  localparam int RB = ROWBEATS;
  localparam int LAT_RD = 1 + (RB + 1) + 1;
  localparam int LAT_WB = 1 + RB + (RB + 1) + 1;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;
  mem_sync_server_if bus ();
  mem_sync_server dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  int raise_cnt [NB];
  int ack_cnt [NB];
  int t_req [NB];
  logic [NB-1:0] force_low, wb_v, req_v, drop1, drop2;
  logic [24:0] cmd_q [$];
  logic [11:0] cs_q [$];
  logic [15:0] ack_q [$];
  int pend, cyc, fire_cnt, cs_cnt, last_lat, errors, checks;
  logic busy_s;
  always_comb
    for (int i = 0; i < NB; i++) req_v[i] = (raise_cnt[i] != ack_cnt[i]) && !force_low[i];
  assign bus.req = req_v;
  assign bus.req_wb = wb_v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_ack"}, bus.ack, 0);
    chk({tag, "_gnt"}, {bus.gnt_bg, bus.gnt_ba}, 0);
    chk({tag, "_valid"}, bus.bs_cmd_valid, 0);
    chk({tag, "_we"}, bus.bs_cmd_we, 0);
    chk({tag, "_bsaddr"}, bus.bs_cmd_addr, 0);
    chk({tag, "_csaddr"}, bus.cs_addr, 0);
    chk({tag, "_cswe"}, bus.cs_we, 0);
  endtask

  // samples the current cycle, then advances to just after the next rising edge
  task automatic tick();
    logic [15:0] a;
    #3;
    if (reset_n) begin
      busy_s = bus.busy;
      if (bus.bs_cmd_valid && bus.bs_cmd_ready) begin
        fire_cnt++;
        chk("cmd_expected", cmd_q.size() != 0, 1);
        if (cmd_q.size() != 0) chk("cmd", {bus.bs_cmd_we, bus.bs_cmd_addr}, cmd_q.pop_front());
        if (!bus.bs_cmd_we) pend++;
      end
      if (bus.cs_we) begin
        cs_cnt++;
        chk("cs_expected", cs_q.size() != 0, 1);
        if (cs_q.size() != 0) chk("cs_addr", bus.cs_addr, cs_q.pop_front());
      end
      a = bus.ack;
      if (a != '0) begin
        chk("ack_expected", ack_q.size() != 0, 1);
        if (ack_q.size() != 0) chk("ack", a, ack_q.pop_front());
        drop1 = a;
        for (int i = 0; i < NB; i++) if (a[i]) last_lat = cyc - t_req[i];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NB; i++) if (drop2[i]) ack_cnt[i]++;
    drop2 = drop1;
    drop1 = '0;
    bus.bs_rvalid = pend > 0;
    if (pend > 0) pend--;
  endtask

  task automatic req_bank(input int bg, input int ba, input logic wb, input logic [16:0] row,
                          input logic [16:0] old, input logic [4:0] crow);
    int i;
    logic [3:0] bi;
    i = int'(bank_idx(bg, ba, BA_W));
    bi = 4'(i);
    wb_v[i] = wb;
    bus.req_row[bg][ba] = row;
    bus.req_old_row[bg][ba] = old;
    bus.req_crow[bg][ba] = crow;
    if (wb) for (int b = 0; b < RB; b++) cmd_q.push_back({1'b1, bi, old, 3'(b)});
    for (int b = 0; b < RB; b++) begin
      cmd_q.push_back({1'b0, bi, row, 3'(b)});
      cs_q.push_back({bi, crow, 3'(b)});
    end
    ack_q.push_back(16'(1) << i);
    t_req[i] = cyc;
    raise_cnt[i]++;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(cmd_q.size() == 0 && cs_q.size() == 0 && ack_q.size() == 0 && !busy_s) && n < budget);
    chk(tag, n < budget, 1);
    repeat (3) tick();
  endtask

  task automatic wait_count(input string tag, input int target, input logic use_cs);
    int n;
    n = 0;
    while ((use_cs ? cs_cnt : fire_cnt) < target && n < 100) begin
      tick();
      n++;
    end
    chk(tag, n < 100, 1);
  endtask

  initial begin
    logic [23:0] saved;
    int base;
    errors = 0; checks = 0; pend = 0; cyc = 0; fire_cnt = 0; cs_cnt = 0; last_lat = 0;
    force_low = '0; wb_v = '0; drop1 = '0; drop2 = '0; busy_s = 1'b0;
    bus.bs_cmd_ready = 1'b1;
    bus.bs_rvalid = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("rst");
    reset_n = 1'b1;
    tick();
    // every bank at once from pointer 0: served 0..15
    for (int i = 0; i < NB; i++)
      req_bank(i / 4, i % 4, i[0], 17'(i * 4099 + 1), 17'(i * 77 + 5), 5'(i + 3));
    wait_done("all16_done", 600);
    req_bank(1, 2, 1'b0, 17'h1ABCD, 17'h00000, 5'd7);
    tick();
    #1;
    chk("gnt_bg", bus.gnt_bg, 1);
    chk("gnt_ba", bus.gnt_ba, 2);
    chk("busy", bus.busy, 1);
    wait_done("rd_done", 60);
    chk("lat_rd", last_lat + 1, LAT_RD);
    req_bank(1, 2, 1'b1, 17'h1ABCD, 17'h00042, 5'd7);
    wait_done("wb_done", 60);
    chk("lat_wb", last_lat + 1, LAT_WB);
    // stall on write beat 3 while the bank's inputs change under the snapshot
    base = fire_cnt;
    req_bank(1, 2, 1'b1, 17'h0F0F0, 17'h12345, 5'd3);
    tick();
    bus.req_row[1][2] = 17'h1FFFF;
    bus.req_old_row[1][2] = 17'h1FFFF;
    bus.req_crow[1][2] = 5'd31;
    wait_count("bp_reach", base + 3, 1'b0);
    bus.bs_cmd_ready = 1'b0;
    #1;
    saved = bus.bs_cmd_addr;
    chk("bp_addr", saved, {4'd6, 17'h12345, 3'd3});
    repeat (5) begin
      #1;
      chk("bp_valid", bus.bs_cmd_valid, 1);
      chk("bp_stable", {bus.bs_cmd_we, bus.bs_cmd_addr}, {1'b1, saved});
      tick();
    end
    bus.bs_cmd_ready = 1'b1;
    wait_done("bp_done", 80);
    bus.bs_rvalid = 1'b1;
    #1;
    chk("stray_cs_we", bus.cs_we, 0);
    tick();
    base = cs_cnt;
    req_bank(2, 1, 1'b0, 17'h0AAAA, 17'h00000, 5'd21);
    wait_count("drop_reach", base + 2, 1'b1);
    force_low[9] = 1'b1;
    wait_done("drop_done", 60);
    repeat (6) tick();
    chk("no_regrant", busy_s, 0);
    force_low[9] = 1'b0;
    req_bank(0, 3, 1'b0, 17'h00333, 17'h0, 5'd1);
    wait_done("b3_done", 60);
    req_bank(0, 0, 1'b0, 17'h00100, 17'h0, 5'd2);
    req_bank(0, 3, 1'b1, 17'h00303, 17'h00404, 5'd4);
    wait_done("rr03_done", 120);
    req_bank(1, 1, 1'b0, 17'h00505, 17'h0, 5'd5);
    req_bank(0, 2, 1'b0, 17'h00202, 17'h0, 5'd6);
    wait_done("rr52_done", 120);
    // reset while fill beat 4 is outstanding
    base = cs_cnt;
    req_bank(3, 0, 1'b0, 17'h15555, 17'h0, 5'd9);
    wait_count("rst_reach", base + 4, 1'b1);
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    cmd_q.delete();
    cs_q.delete();
    ack_q.delete();
    pend = 0;
    ack_cnt[12] = raise_cnt[12];
    drop1 = '0;
    drop2 = '0;
    bus.bs_rvalid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    req_bank(1, 1, 1'b1, 17'h0BEEF, 17'h0CAFE, 5'd11);
    wait_done("post_rst_done", 60);
    chk("post_rst_lat", last_lat + 1, LAT_WB);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
